// File: rtl/audio_adc_scanner_if.sv
// Sample-pair handshake between the ADC scanner and the HDMI audio sample consumer.
interface audio_adc_scanner_if #(
  parameter int OUT_WIDTH = 16
) ();
  logic [OUT_WIDTH-1:0] sample_l;
  logic [OUT_WIDTH-1:0] sample_r;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_adc_scanner.sv
// SPI MCP320x audio front end: scans 1 or 2 channels round-robin, averages
// 2^DECIM_LOG2 conversions per channel and presents an L/R pair on a
// valid/ready handshake. One clock drives the SCK generator, FSM and outputs.
module audio_adc_scanner #(
  parameter int CHANNELS   = 2,
  parameter int SGL        = 1,
  parameter int SCK_DIV    = 34,
  parameter int CS_IDLE    = 68,
  parameter int DECIM_LOG2 = 2,
  parameter int OUT_WIDTH  = 16,
  parameter int SIGNED_OUT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                adc_sck,
  output logic                adc_cs_n,
  output logic                adc_mosi,
  input  logic                adc_miso,
  audio_adc_scanner_if.master smp,
  output logic                overrun
);

  localparam int AW   = 12 + DECIM_LOG2;
  localparam int CMAX = (SCK_DIV > CS_IDLE) ? SCK_DIV : CS_IDLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = DECIM_LOG2 + 1;

  localparam logic [CW-1:0] SCK_LAST  = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(CS_IDLE - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'((1 << DECIM_LOG2) - 1);
  localparam logic [4:0]    LAST_BIT  = 5'd16;
  localparam logic [4:0]    FIRST_CAP = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic [4:0]      bit_cnt;
  logic [11:0]     shreg;
  logic            ch;
  logic [AW-1:0]   acc [2];
  logic [DW-1:0]   dcnt;
  logic            pair_pend;
  logic            miso_meta;
  logic            miso_sync;

  logic [OUT_WIDTH-1:0] out_l;
  logic [OUT_WIDTH-1:0] out_r;
  logic                 valid_q;

  assign smp.sample_l     = out_l;
  assign smp.sample_r     = out_r;
  assign smp.sample_valid = valid_q;

  // Command bit driven while SCK n (1-based) is low: start, SGL/DIFF, ODD, MSBF.
  function automatic logic cmd_bit(input logic [4:0] n, input logic odd);
    case (n)
      5'd1:    cmd_bit = 1'b1;
      5'd2:    cmd_bit = (SGL != 0);
      5'd3:    cmd_bit = odd;
      5'd4:    cmd_bit = 1'b1;
      default: cmd_bit = 1'b0;
    endcase
  endfunction

  // Keep the 12 MSBs of the average, left-justified; optional offset-binary to two's complement.
  function automatic logic [OUT_WIDTH-1:0] to_out(input logic [AW-1:0] a);
    logic [OUT_WIDTH-1:0] o;
    o = '0;
    o[OUT_WIDTH-1 -: 12] = a[AW-1 -: 12];
    if (SIGNED_OUT != 0) o[OUT_WIDTH-1] = ~o[OUT_WIDTH-1];
    return o;
  endfunction

  // Two-flop synchroniser for the asynchronous ADC data line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= adc_miso;
      miso_sync <= miso_meta;
    end
  end

  // Conversion FSM: chip select framing, SCK generation, capture and accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ch        <= 1'b0;
      dcnt      <= '0;
      pair_pend <= 1'b0;
      adc_sck   <= 1'b0;
      adc_cs_n  <= 1'b1;
      adc_mosi  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) acc[i] <= '0;
    end else begin
      // The pair is formed one clock after the final accumulate; clearing
      // here cannot collide with the next accumulate (CS_HOLD >= 1 clk).
      if (pair_pend) begin
        pair_pend <= 1'b0;
        dcnt      <= '0;
        for (int unsigned i = 0; i < 2; i++) acc[i] <= '0;
      end

      case (state)
        S_IDLE: begin
          adc_sck  <= 1'b0;
          adc_cs_n <= 1'b1;
          adc_mosi <= 1'b0;
          if (enable) begin
            state    <= S_CS_SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
          end
        end

        S_CS_SETUP: begin
          if (div_cnt == SCK_LAST) begin
            state    <= S_SHIFT;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_mosi <= cmd_bit(5'd1, ch);
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        S_SHIFT: begin
          if (div_cnt == SCK_LAST) begin
            div_cnt <= '0;
            if (!adc_sck) begin
              adc_sck <= 1'b1;
              if (bit_cnt >= FIRST_CAP) shreg <= {shreg[10:0], miso_sync};
            end else begin
              adc_sck <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state    <= S_CS_HOLD;
                adc_cs_n <= 1'b1;
                adc_mosi <= 1'b0;
                acc[ch]  <= acc[ch] + AW'(shreg);
                if (CHANNELS == 1 || ch) begin
                  ch   <= 1'b0;
                  dcnt <= dcnt + DW'(1);
                  if (dcnt == DEC_LAST) pair_pend <= 1'b1;
                end else begin
                  ch <= 1'b1;
                end
              end else begin
                bit_cnt  <= bit_cnt + 5'd1;
                adc_mosi <= cmd_bit(bit_cnt + 5'd2, ch);
              end
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        S_CS_HOLD: begin
          if (div_cnt == IDLE_LAST) begin
            div_cnt <= '0;
            if (enable) begin
              state    <= S_CS_SETUP;
              adc_cs_n <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Output pair register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_l   <= '0;
      out_r   <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else if (pair_pend) begin
      if (!valid_q || smp.sample_ready) begin
        out_l   <= to_out(acc[0]);
        out_r   <= (CHANNELS == 1) ? to_out(acc[0]) : to_out(acc[1]);
        valid_q <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid_q && smp.sample_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
